// File: rtl/axis_averager_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// averager_pkg
// Shared definitions for the AXI-Stream averager sequencer slice:
//   - FSM state encoding (IDLE / ARM / RUN)
//   - default sizing for frame address width and log-count saturation
//   - helper that saturates a requested log count
// ---------------------------------------------------------------------------
package averager_pkg;

  // Width of the log-count ports towards the averager.
  localparam int unsigned LOG_COUNT_W          = 5;

  // Default log2(points per frame); equals the averager BRAM address width.
  localparam int unsigned FRAME_ADDR_WIDTH_DEF = 10;

  // Default saturation limit for the latched log count.
  localparam int unsigned MAX_LOG_COUNT_DEF    = 16;

  // Sequencer state encoding.
  localparam int unsigned STATE_W = 2;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_ARM  = 2'd1;
  localparam logic [1:0]  ST_RUN  = 2'd2;

  // Clamp a requested log count to the configured maximum.
  function automatic logic [LOG_COUNT_W-1:0] sat_log_count(
    input logic [LOG_COUNT_W-1:0] req,
    input int unsigned            max_lc
  );
    if (32'(req) > max_lc) begin
      return LOG_COUNT_W'(max_lc);
    end
    return req;
  endfunction

endpackage

// File: rtl/axis_averager_sequencer_if.sv
// ---------------------------------------------------------------------------
// axis_averager_sequencer_if
// Handshake bundle around the averager:
//   S_AXIS_*      upstream source -> sequencer
//   AVG_S_AXIS_*  sequencer -> averager input (tvalid only; tdata bypasses)
//   AVG_M_AXIS_*  averager output <-> sequencer
//   M_AXIS_*      sequencer -> downstream sink (tdata bypasses)
// Modports:
//   master  the sequencer's view
//   slave   the surrounding fabric's view (source, averager, sink)
// ---------------------------------------------------------------------------
interface axis_averager_sequencer_if;

  logic S_AXIS_tvalid;
  logic S_AXIS_tready;
  logic AVG_S_AXIS_tvalid;
  logic AVG_M_AXIS_tready;
  logic AVG_M_AXIS_tvalid;
  logic M_AXIS_tvalid;
  logic M_AXIS_tlast;
  logic M_AXIS_tready;

  modport master (
    input  S_AXIS_tvalid,
    input  AVG_M_AXIS_tvalid,
    input  M_AXIS_tready,
    output S_AXIS_tready,
    output AVG_S_AXIS_tvalid,
    output AVG_M_AXIS_tready,
    output M_AXIS_tvalid,
    output M_AXIS_tlast
  );

  modport slave (
    output S_AXIS_tvalid,
    output AVG_M_AXIS_tvalid,
    output M_AXIS_tready,
    input  S_AXIS_tready,
    input  AVG_S_AXIS_tvalid,
    input  AVG_M_AXIS_tready,
    input  M_AXIS_tvalid,
    input  M_AXIS_tlast
  );

endinterface

// File: rtl/axis_averager_sequencer_pass_counter.sv
// ---------------------------------------------------------------------------
// averager_pass_counter
// Sample and pass counters for the averager sequencer plus output-pass decode.
// The sample counter walks one frame (2^FRAME_ADDR_WIDTH beats); each frame
// wrap advances the pass counter. A pass P is an output pass when P != 0 and
// P is a multiple of 2^log_count.
// Ports:
//   aclk, aresetn    clock, synchronous active-low reset
//   clear            synchronous clear of both counters
//   beat             one accepted input beat
//   log_count        latched, saturated log2 of frames averaged
//   sample_last_c    sample counter is on the last point of the frame
//   out_pass_c       current pass produces a result frame
//   final_pass_c     current pass is pass 2^log_count
// ---------------------------------------------------------------------------
module averager_pass_counter
  import averager_pkg::*;
#(
  parameter int unsigned FRAME_ADDR_WIDTH = FRAME_ADDR_WIDTH_DEF,
  parameter int unsigned MAX_LOG_COUNT    = MAX_LOG_COUNT_DEF
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   clear,
  input  logic                   beat,
  input  logic [LOG_COUNT_W-1:0] log_count,
  output logic                   sample_last_c,
  output logic                   out_pass_c,
  output logic                   final_pass_c
);

  localparam int unsigned PASS_W = MAX_LOG_COUNT + 1;

  logic [FRAME_ADDR_WIDTH-1:0] sample_cnt;
  logic [PASS_W-1:0]           pass_cnt;
  logic [PASS_W-1:0]           frame_period;
  logic [PASS_W-1:0]           pass_mask;
  logic [PASS_W-1:0]           pass_inc;

  // 2^L passes between result frames; log_count is already saturated.
  assign frame_period  = PASS_W'(1) << log_count;
  assign pass_mask     = frame_period - PASS_W'(1);

  assign sample_last_c = &sample_cnt;
  assign out_pass_c    = (pass_cnt != '0) && ((pass_cnt & pass_mask) == '0);
  assign final_pass_c  = (pass_cnt == frame_period);

  // On overflow skip back to 2^L instead of 0: keeps the 2^L alignment and
  // never re-enters pass 0, whose BRAM contents would be stale.
  assign pass_inc = (&pass_cnt) ? frame_period : pass_cnt + PASS_W'(1);

  // Sample/pass counting.
  always_ff @(posedge aclk) begin
    if (!aresetn || clear) begin
      sample_cnt <= '0;
      pass_cnt   <= '0;
    end else if (beat) begin
      sample_cnt <= sample_cnt + FRAME_ADDR_WIDTH'(1);
      if (sample_last_c) begin
        pass_cnt <= pass_inc;
      end
    end
  end

endmodule

// File: rtl/axis_averager_sequencer.sv
// ---------------------------------------------------------------------------
// axis_averager_sequencer
// Controls a frame averager: resets it, gates its input stream, holds back
// the passes whose output is not a finished average, and reports completion.
// Optional feature macro: AVG_SEQ_CONTINUOUS_EN adds the 'continuous' input;
// when latched high at start the run emits a result frame every 2^L passes
// until aborted instead of stopping after the first one.
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   start           run request (IDLE only)
//   abort           cancel, honoured in any state
//   continuous      (AVG_SEQ_CONTINUOUS_EN only) free-running mode, latched
//   log_count_in    requested log2 of frames averaged
//   log_count_out   latched, saturated log count to the averager
//   avg_aresetn     registered reset to the averager
//   busy            high outside IDLE
//   done            one-cycle pulse per completed result frame
//   aborted         one-cycle pulse on an honoured abort
//   axis            handshake bundle (master modport)
// ---------------------------------------------------------------------------
module axis_averager_sequencer
  import averager_pkg::*;
#(
  parameter int unsigned FRAME_ADDR_WIDTH = FRAME_ADDR_WIDTH_DEF,
  parameter int unsigned MAX_LOG_COUNT    = MAX_LOG_COUNT_DEF
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic                   abort,
`ifdef AVG_SEQ_CONTINUOUS_EN
  input  logic                   continuous,
`endif
  input  logic [LOG_COUNT_W-1:0] log_count_in,
  output logic [LOG_COUNT_W-1:0] log_count_out,
  output logic                   avg_aresetn,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  axis_averager_sequencer_if.master axis
);

  logic [STATE_W-1:0]     state;
  logic [STATE_W-1:0]     state_next;
  logic [LOG_COUNT_W-1:0] log_count_next;
  logic                   cont_q;
  logic                   cont_next;
  logic                   cont_in_c;
  logic                   avg_aresetn_next;
  logic                   busy_next;
  logic                   done_next;
  logic                   aborted_next;

  logic                   in_run_c;
  logic                   avg_m_tready_c;
  logic                   m_tvalid_c;
  logic                   beat_c;
  logic                   m_last_hs_c;
  logic                   last_beat_c;
  logic                   cnt_clear_c;

  logic                   sample_last_c;
  logic                   out_pass_c;
  logic                   final_pass_c;

`ifdef AVG_SEQ_CONTINUOUS_EN
  assign cont_in_c = continuous;
`else
  assign cont_in_c = 1'b0;
`endif

  // Stream gating: the averager's output ready also paces its input, so it
  // is throttled by the sink only while results are actually emitted.
  assign in_run_c               = (state == ST_RUN);
  assign avg_m_tready_c         = in_run_c && (out_pass_c ? axis.M_AXIS_tready : 1'b1);
  assign m_tvalid_c             = axis.AVG_M_AXIS_tvalid && out_pass_c && in_run_c;

  assign axis.AVG_M_AXIS_tready = avg_m_tready_c;
  assign axis.S_AXIS_tready     = avg_m_tready_c;
  assign axis.AVG_S_AXIS_tvalid = axis.S_AXIS_tvalid && in_run_c;
  assign axis.M_AXIS_tvalid     = m_tvalid_c;
  assign axis.M_AXIS_tlast      = m_tvalid_c && sample_last_c;

  assign beat_c      = in_run_c && axis.S_AXIS_tvalid && avg_m_tready_c;
  assign m_last_hs_c = m_tvalid_c && axis.M_AXIS_tready && sample_last_c;
  assign last_beat_c = beat_c && sample_last_c && final_pass_c && !cont_q;
  assign cnt_clear_c = !in_run_c || abort;

  // Frame/pass bookkeeping.
  averager_pass_counter #(
    .FRAME_ADDR_WIDTH (FRAME_ADDR_WIDTH),
    .MAX_LOG_COUNT    (MAX_LOG_COUNT)
  ) u_pass_counter (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .clear         (cnt_clear_c),
    .beat          (beat_c),
    .log_count     (log_count_out),
    .sample_last_c (sample_last_c),
    .out_pass_c    (out_pass_c),
    .final_pass_c  (final_pass_c)
  );

  // Next-state and registered-output decode; abort overrides everything.
  always_comb begin
    state_next     = state;
    log_count_next = log_count_out;
    cont_next      = cont_q;
    done_next      = 1'b0;
    aborted_next   = 1'b0;

    if (abort) begin
      state_next   = ST_IDLE;
      aborted_next = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_next     = ST_ARM;
            log_count_next = sat_log_count(log_count_in, MAX_LOG_COUNT);
            cont_next      = cont_in_c;
          end
        end
        ST_ARM: begin
          state_next = ST_RUN;
        end
        ST_RUN: begin
          done_next = m_last_hs_c;
          if (last_beat_c) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    busy_next        = (state_next != ST_IDLE);
    // Averager leaves reset one cycle after ARM is entered.
    avg_aresetn_next = (state != ST_IDLE) && (state_next != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      log_count_out <= '0;
      cont_q        <= 1'b0;
      avg_aresetn   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      state         <= state_next;
      log_count_out <= log_count_next;
      cont_q        <= cont_next;
      avg_aresetn   <= avg_aresetn_next;
      busy          <= busy_next;
      done          <= done_next;
      aborted       <= aborted_next;
    end
  end

endmodule
